a2d_conv_sched: RTL and testbench
=================================

# a2d_conv_sched

Round-robin conversion scheduler that shares the single SPI master between the four eBike analog channels: battery, current, brake and torque. On a fixed interval it runs the two-transaction A2D conversion for the next channel and stores the 12-bit result in a per-channel holding register. The registers feed the telemetry, brake and torque/PID logic, and the scheduler is the only SPI master client.

## Interface
- CH_INTERVAL, 16384: clock cycles between conversion starts (2..65535).
- GAP_CYCLES, 2: idle cycles between the command and read transactions (1..15).
- TIMEOUT, 4096: cycles allowed for each SPI `done` before the conversion is aborted.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- spi_wrt  out  1  one-cycle pulse that starts an SPI transaction.
- spi_cmd  out  16  SPI transmit word.
- spi_done  in  1  one-cycle pulse from the SPI master: transaction complete.
- spi_rd_data  in  16  SPI receive word; valid in the `spi_done` cycle.
- batt, curr, brake, torque  out  12 each  latest conversion results.
- cnv_cmplt  out  1  one-cycle pulse when a result register updates.
- cnv_err  out  1  sticky flag, set on timeout and cleared only by `rst`.

## Operation
- Channel order and A2D codes: batt=3'd0, curr=3'd1, brake=3'd3, torque=3'd4. After torque the order wraps to batt.
- Interval timer: 16-bit, free-running, wraps at CH_INTERVAL-1. Its wrap produces a one-cycle `tick`.
- State machine:
  - IDLE: on `tick`, go to CMD.
  - CMD: assert `spi_wrt`; `spi_cmd` = {2'b00, chnl, 11'h000}; go to WAIT1.
  - WAIT1: on `spi_done`, go to GAP. Receive data is ignored.
  - GAP: count GAP_CYCLES, then go to READ.
  - READ: assert `spi_wrt`; `spi_cmd` = 16'h0000; go to WAIT2.
  - WAIT2: on `spi_done`, capture `spi_rd_data[11:0]` and go to STORE.
  - STORE: write the captured value to the current channel's register; pulse `cnv_cmplt`; advance the channel pointer; return to IDLE.
- `spi_cmd` holds its value from the `spi_wrt` cycle until the next `spi_wrt`.
- `tick` outside IDLE is dropped. Ticks are never queued, and the timer keeps free-running.
- `spi_done` outside WAIT1/WAIT2 is ignored.
- Timeout: a counter clears on entry to WAIT1 and to WAIT2. If it reaches TIMEOUT-1 before `spi_done`:
  - `cnv_err` sets.
  - The channel pointer advances and the channel's register is left unchanged.
  - The state returns to IDLE.
  - `cnv_cmplt` does not pulse.
- Reset values:
  - State IDLE, channel pointer at batt, timer 0.
  - `spi_wrt`, `cnv_cmplt` and `cnv_err` 0.
  - `spi_cmd` 16'h0000.
  - All result registers 12'h000.
- Reset mid-conversion returns everything to reset values on the next edge. The SPI master is reset by the same `rst`.

## Timing
- Let cycle T be the `tick` cycle. State is CMD at T+1 and `spi_wrt` is high only during T+1.
- `spi_done` in cycle D1 → GAP from D1+1. The second `spi_wrt` is high in cycle D1+1+GAP_CYCLES.
- `spi_done` in cycle D2 → the result register and `cnv_cmplt` are both updated in cycle D2+1. The next channel is eligible from the next `tick`.
- `spi_wrt` and `cnv_cmplt` are registered outputs, never asserted for consecutive cycles.
- `spi_done` in the same cycle as timeout expiry: `done` wins and no error is flagged.

## Structure
- Shared package `a2d_pkg` holds:
  - the state enum typedef (IDLE, CMD, WAIT1, GAP, READ, WAIT2, STORE);
  - the channel-code localparams (CH_BATT, CH_CURR, CH_BRAKE, CH_TORQUE);
  - the 12-bit result typedef.
- One sub-module, `a2d_interval_tmr`: counter plus `tick` generation, parameterised by CH_INTERVAL.
- The FSM, timeout counter and result registers stay in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles → all result registers 0, `spi_cmd`=0, `spi_wrt`=0, `cnv_err`=0; the first `spi_wrt` appears CH_INTERVAL+1 cycles after reset release.
- Single conversion (CH_INTERVAL=64, GAP_CYCLES=2): the SPI model returns 16'h0ABC on the read → first `spi_cmd`=16'h0000 (batt), `batt`=12'hABC, `cnv_cmplt` pulses once in cycle D2+1, and the second `spi_wrt` is 3 cycles after D1.
- Round order: run 5 conversions → `spi_cmd` channel fields are 0,1,3,4,0, and batt, curr, brake and torque each hold their distinct model value.
- Overlap: the SPI model delays `done` beyond CH_INTERVAL → the intervening tick is dropped, there is no extra `spi_wrt`, and the next conversion starts at the following tick.
- Timeout: `done` is never returned (TIMEOUT=32) → `cnv_err`=1, the target register is unchanged, no `cnv_cmplt`, and the next tick converts the next channel.
- Reset mid-WAIT2: assert `rst` → the result register is not written, `cnv_cmplt` stays 0, and the next conversion restarts at batt.

Source files
------------

// File: rtl/a2d_pkg.sv
// Shared types and channel codes for the A2D conversion scheduler.
package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WAIT1,
      GAP,
      READ,
      WAIT2,
      STORE
   } a2dState_t;

   localparam logic [2:0] CH_BATT   = 3'd0;
   localparam logic [2:0] CH_CURR   = 3'd1;
   localparam logic [2:0] CH_BRAKE  = 3'd3;
   localparam logic [2:0] CH_TORQUE = 3'd4;

   typedef logic [11:0] a2dResult_t;

   // Maps the round-robin slot index onto the A2D mux code for that channel.
   function automatic logic [2:0] chnlCode(input logic [1:0] idx);
      logic [2:0] code;
      case (idx)
         2'd0:    code = CH_BATT;
         2'd1:    code = CH_CURR;
         2'd2:    code = CH_BRAKE;
         default: code = CH_TORQUE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/a2d_interval_tmr.sv
// Free-running conversion interval timer; emits a one-cycle tick on each wrap.
module a2d_interval_tmr #(
   parameter int CH_INTERVAL = 16384
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [15:0] TMR_LAST = 16'(CH_INTERVAL - 1);

   logic [15:0] tmrCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmrCnt <= 16'd0;
         tick   <= 1'b0;
      end else if (tmrCnt == TMR_LAST) begin
         tmrCnt <= 16'd0;
         tick   <= 1'b1;
      end else begin
         tmrCnt <= tmrCnt + 16'd1;
         tick   <= 1'b0;
      end
   end

endmodule

// File: rtl/a2d_conv_sched.sv
// Round-robin A2D conversion scheduler: sole SPI master client, one channel
// converted per interval tick, results held per channel.
module a2d_conv_sched
   import a2d_pkg::*;
#(
   parameter int CH_INTERVAL = 16384,
   parameter int GAP_CYCLES  = 2,
   parameter int TIMEOUT     = 4096
) (
   input  logic        clk,
   input  logic        rst,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data,
   output a2dResult_t  batt,
   output a2dResult_t  curr,
   output a2dResult_t  brake,
   output a2dResult_t  torque,
   output logic        cnv_cmplt,
   output logic        cnv_err
);

   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   a2dState_t   state, nxtState;
   logic        tick;
   logic        timedOut;
   logic [1:0]  chIdx;
   logic [15:0] waitCnt;

   a2d_interval_tmr #(
      .CH_INTERVAL(CH_INTERVAL)
   ) uTmr (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // A done arriving in the expiry cycle is honoured, so it is tested first.
   always_comb begin
      nxtState = state;
      timedOut = 1'b0;
      case (state)
         IDLE:  if (tick) nxtState = CMD;
         CMD:   nxtState = WAIT1;
         WAIT1: begin
            if (spi_done) begin
               nxtState = GAP;
            end else if (waitCnt == TO_LAST) begin
               nxtState = IDLE;
               timedOut = 1'b1;
            end
         end
         GAP:   if (waitCnt == GAP_LAST) nxtState = READ;
         READ:  nxtState = WAIT2;
         WAIT2: begin
            if (spi_done) begin
               nxtState = STORE;
            end else if (waitCnt == TO_LAST) begin
               nxtState = IDLE;
               timedOut = 1'b1;
            end
         end
         STORE: nxtState = IDLE;
         default: nxtState = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         chIdx     <= 2'd0;
         waitCnt   <= 16'd0;
         spi_wrt   <= 1'b0;
         spi_cmd   <= 16'h0000;
         cnv_cmplt <= 1'b0;
         cnv_err   <= 1'b0;
         batt      <= '0;
         curr      <= '0;
         brake     <= '0;
         torque    <= '0;
      end else begin
         state     <= nxtState;
         waitCnt   <= (nxtState != state) ? 16'd0 : waitCnt + 16'd1;
         spi_wrt   <= (nxtState == CMD) || (nxtState == READ);
         cnv_cmplt <= (nxtState == STORE);
         if (nxtState == CMD) begin
            spi_cmd <= {2'b00, chnlCode(chIdx), 11'h000};
         end else if (nxtState == READ) begin
            spi_cmd <= 16'h0000;
         end
         if (timedOut) begin
            cnv_err <= 1'b1;
         end
         if (timedOut || (state == STORE)) begin
            chIdx <= chIdx + 2'd1;
         end
         if ((state == WAIT2) && (nxtState == STORE)) begin
            case (chIdx)
               2'd0:    batt   <= spi_rd_data[11:0];
               2'd1:    curr   <= spi_rd_data[11:0];
               2'd2:    brake  <= spi_rd_data[11:0];
               default: torque <= spi_rd_data[11:0];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Directed bench for a2d_conv_sched with a behavioural SPI master responder.
module tb_a2d_conv_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_rd_data;
   logic [11:0] batt, curr, brake, torque;
   logic        cnv_cmplt;
   logic        cnv_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rstRel = 0;
   int backToBack = 0;
   logic prevWrt = 1'b0;

   int          doneDelay = 4;
   logic        noDone = 1'b0;
   logic        skipZero = 1'b0;
   logic [15:0] respData = 16'h0000;

   int          wrtCyc[$];
   logic [15:0] wrtCmd[$];
   int          doneCyc[$];
   int          cmpltCyc[$];
   logic [11:0] cmpltBatt[$];

   a2d_conv_sched #(
      .CH_INTERVAL(64),
      .GAP_CYCLES (2),
      .TIMEOUT    (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_wrt    (spi_wrt),
      .spi_cmd    (spi_cmd),
      .spi_done   (spi_done),
      .spi_rd_data(spi_rd_data),
      .batt       (batt),
      .curr       (curr),
      .brake      (brake),
      .torque     (torque),
      .cnv_cmplt  (cnv_cmplt),
      .cnv_err    (cnv_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic waitFor(input string tag, input int which, input int target, input int budget);
      int n;
      for (int i = 0; i < budget; i++) begin
         n = (which == 0) ? wrtCyc.size() : cmpltCyc.size();
         if (n >= target) break;
         @(negedge clk);
      end
      n = (which == 0) ? wrtCyc.size() : cmpltCyc.size();
      chk(tag, n, target);
   endtask

   // Event recorder, sampled mid-cycle.
   always @(negedge clk) begin
      if (spi_wrt) begin
         wrtCyc.push_back(cyc);
         wrtCmd.push_back(spi_cmd);
      end
      if (spi_done) doneCyc.push_back(cyc);
      if (cnv_cmplt) begin
         cmpltCyc.push_back(cyc);
         cmpltBatt.push_back(batt);
      end
      if (spi_wrt && prevWrt) backToBack++;
      prevWrt = spi_wrt;
   end

   // SPI master model: done pulses doneDelay cycles after each spi_wrt.
   always begin
      @(negedge clk);
      if (spi_wrt && !noDone && !(skipZero && (spi_cmd == 16'h0000))) begin
         repeat (doneDelay) @(posedge clk);
         #1;
         spi_done    = 1'b1;
         spi_rd_data = respData;
         @(posedge clk);
         #1;
         spi_done = 1'b0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [15:0] convData [4];
      int          chExp [5];
      int          nW, nC;
      convData = '{16'hF123, 16'h7456, 16'h3789, 16'h05A5};
      chExp    = '{0, 1, 3, 4, 0};
      rst = 1'b1;
      spi_done = 1'b0;
      spi_rd_data = 16'h0000;

      repeat (2) @(posedge clk);
      #1;
      chk("rstBatt", batt, 12'h000);
      chk("rstCurr", curr, 12'h000);
      chk("rstBrake", brake, 12'h000);
      chk("rstTorque", torque, 12'h000);
      chk("rstCmd", spi_cmd, 16'h0000);
      chk("rstWrt", spi_wrt, 1'b0);
      chk("rstErr", cnv_err, 1'b0);
      chk("rstCmplt", cnv_cmplt, 1'b0);
      rst = 1'b0;
      rstRel = cyc;

      // Single conversion on batt
      respData = 16'h0ABC;
      waitFor("conv1Done", 1, 1, 300);
      chk("firstWrtLat", wrtCyc[0] - rstRel, 65);
      chk("conv1Cmd", wrtCmd[0], 16'h0000);
      chk("gapToRead", wrtCyc[1] - doneCyc[0], 3);
      chk("readCmd", wrtCmd[1], 16'h0000);
      chk("cmpltLat", cmpltCyc[0] - doneCyc[1], 1);
      chk("battAtCmplt", cmpltBatt[0], 12'hABC);
      repeat (10) @(negedge clk);
      chk("cmpltOnce", cmpltCyc.size(), 1);
      chk("battVal", batt, 12'hABC);

      // Round order through the remaining channels and back to batt
      for (int i = 0; i < 4; i++) begin
         respData = convData[i];
         waitFor("roundDone", 1, i + 2, 200);
      end
      for (int i = 0; i < 5; i++) begin
         chk("roundChan", wrtCmd[2 * i][13:11], chExp[i]);
      end
      chk("roundBatt", batt, 12'h5A5);
      chk("roundCurr", curr, 12'h123);
      chk("roundBrake", brake, 12'h456);
      chk("roundTorque", torque, 12'h789);

      // Overlap: slow SPI pushes the conversion past the next tick
      doneDelay = 30;
      respData = 16'h0321;
      waitFor("ovlDone", 1, 6, 300);
      doneDelay = 4;
      respData = 16'h0654;
      waitFor("ovlNext", 1, 7, 300);
      chk("ovlReadGap", wrtCyc[11] - wrtCyc[10], 33);
      chk("ovlTickDrop", wrtCyc[12] - wrtCyc[10], 128);
      chk("ovlCmpltLat", cmpltCyc[5] - wrtCyc[10], 64);
      chk("ovlCurr", curr, 12'h321);
      chk("ovlBrake", brake, 12'h654);

      // Timeout on torque
      nW = wrtCyc.size();
      nC = cmpltCyc.size();
      chk("errBefore", cnv_err, 1'b0);
      noDone = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (cnv_err) break;
         @(negedge clk);
      end
      chk("errSet", cnv_err, 1'b1);
      chk("toTorqueCmd", wrtCmd[nW], 16'h2000);
      chk("toTorqueKept", torque, 12'h789);
      chk("toNoCmplt", cmpltCyc.size(), nC);
      chk("toNoRead", wrtCyc.size(), nW + 1);
      noDone = 1'b0;
      respData = 16'h0ACE;
      waitFor("toNextDone", 1, nC + 1, 200);
      chk("toNextChan", wrtCmd[nW + 1], 16'h0000);
      chk("toNextBatt", batt, 12'hACE);
      chk("errSticky", cnv_err, 1'b1);

      // Reset while waiting for the curr read
      nW = wrtCyc.size();
      nC = cmpltCyc.size();
      skipZero = 1'b1;
      waitFor("rstMidRead", 0, nW + 2, 200);
      chk("rstMidCmd", wrtCmd[nW], 16'h0800);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rstMidCurr", curr, 12'h000);
      chk("rstMidBatt", batt, 12'h000);
      chk("rstMidErr", cnv_err, 1'b0);
      chk("rstMidWrt", spi_wrt, 1'b0);
      rst = 1'b0;
      rstRel = cyc;
      skipZero = 1'b0;
      chk("rstMidNoCmplt", cmpltCyc.size(), nC);
      respData = 16'h0BEE;
      waitFor("rstMidNext", 1, nC + 1, 300);
      chk("rstMidLat", wrtCyc[nW + 2] - rstRel, 65);
      chk("rstMidChan", wrtCmd[nW + 2], 16'h0000);
      chk("rstMidNewBatt", batt, 12'hBEE);
      chk("rstMidCurrKept", curr, 12'h000);
      chk("noBackToBack", backToBack, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
